// File: rtl/result_tx_formatter.sv
// Formats a signed result as an ASCII decimal line (or "ERR") terminated by CR LF
// and hands it character by character to the serial transmitter.
module result_tx_formatter #(
  parameter int WIDTH = 16
) (
  input  logic                    USER_CLK,
  input  logic                    USER_RST_N,
  input  logic                    Result_Valid,
  input  logic signed [WIDTH-1:0] Result,
  input  logic                    Result_Error,
  output logic                    Result_Ready,
  output logic                    TX_Request,
  output logic [7:0]              TX_Data,
  input  logic                    Busy
);

  localparam int DIGITS = 5;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int BUF_N  = 8;

  typedef enum logic [2:0] {
    IDLE, CONVERT, FORMAT, WAIT_FREE, REQ, WAIT_HI, WAIT_LO, NEXT
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mag;
  logic [BCD_W-1:0]   bcd;
  logic               neg;
  logic               err;
  logic [3:0]         shift_cnt;
  logic [7:0]         char_buf [BUF_N];
  logic [7:0]         fmt_buf  [BUF_N];
  logic [3:0]         fmt_len;
  logic [3:0]         len;
  logic [2:0]         idx;
  logic               last_char;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int d = 0; d < DIGITS; d++) begin
      if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign last_char = ({1'b0, idx} == (len - 4'd1));

  always_comb begin
    state_nxt    = state;
    Result_Ready = 1'b0;
    TX_Request   = 1'b0;
    case (state)
      IDLE: begin
        Result_Ready = 1'b1;
        if (Result_Valid) state_nxt = Result_Error ? FORMAT : CONVERT;
      end
      CONVERT:   if (shift_cnt == 4'(WIDTH - 1)) state_nxt = FORMAT;
      FORMAT:    state_nxt = WAIT_FREE;
      WAIT_FREE: if (!Busy) state_nxt = REQ;
      REQ: begin
        TX_Request = 1'b1;
        state_nxt  = WAIT_HI;
      end
      WAIT_HI:   if (Busy) state_nxt = WAIT_LO;
      WAIT_LO:   if (!Busy) state_nxt = NEXT;
      NEXT:      state_nxt = last_char ? IDLE : REQ;
      default:   state_nxt = IDLE;
    endcase
  end

  // Line assembly: optional sign, digits without leading zeros (at least one), CR LF.
  always_comb begin
    int  pos;
    logic started;
    logic [3:0] digit;
    for (int i = 0; i < BUF_N; i++) fmt_buf[i] = 8'h00;
    pos     = 0;
    started = 1'b0;
    digit   = 4'd0;
    if (err) begin
      fmt_buf[0] = 8'h45;
      fmt_buf[1] = 8'h52;
      fmt_buf[2] = 8'h52;
      pos = 3;
    end else begin
      if (neg) begin
        fmt_buf[pos] = 8'h2D;
        pos = pos + 1;
      end
      for (int d = DIGITS - 1; d >= 0; d--) begin
        digit = bcd[4*d +: 4];
        if (digit != 4'd0 || started || d == 0) begin
          fmt_buf[pos] = {4'h3, digit};
          pos     = pos + 1;
          started = 1'b1;
        end
      end
    end
    fmt_buf[pos]     = 8'h0D;
    fmt_buf[pos + 1] = 8'h0A;
    fmt_len = 4'(pos + 2);
  end

  always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
    if (!USER_RST_N) begin
      state     <= IDLE;
      mag       <= '0;
      bcd       <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
      shift_cnt <= '0;
      len       <= '0;
      idx       <= '0;
      TX_Data   <= 8'h00;
      for (int i = 0; i < BUF_N; i++) char_buf[i] <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (Result_Valid) begin
            err       <= Result_Error;
            neg       <= Result[WIDTH-1];
            mag       <= Result[WIDTH-1] ? $unsigned(-Result) : $unsigned(Result);
            bcd       <= '0;
            shift_cnt <= '0;
          end
        end
        CONVERT: begin
          {bcd, mag} <= {dabble_adjust(bcd), mag} << 1;
          shift_cnt  <= shift_cnt + 4'd1;
        end
        FORMAT: begin
          char_buf <= fmt_buf;
          len      <= fmt_len;
          idx      <= '0;
        end
        WAIT_FREE: if (!Busy) TX_Data <= char_buf[idx];
        NEXT: begin
          idx <= idx + 3'd1;
          if (!last_char) TX_Data <= char_buf[idx + 3'd1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_tx_formatter.sv
// Scoreboard bench for result_tx_formatter with a simple transmitter Busy model.
module tb_result_tx_formatter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              result_valid;
  logic signed [15:0] result;
  logic              result_error;
  logic              result_ready;
  logic              tx_request;
  logic [7:0]        tx_data;
  logic              busy;

  logic              busy_tx = 1'b0;
  logic              busy_force;
  int                busy_cnt = 0;
  int                frame_len;
  int                cyc = 0;

  logic [7:0]        exp_q[$];
  int                n_checks = 0;
  int                n_pass = 0;
  int                req_count = 0;
  int                last_req_cyc = 0;
  logic              prev_req = 1'b0;
  int                acc_cyc;
  int                line_start;
  int                line_len;

  always #5 clk = ~clk;

  result_tx_formatter #(.WIDTH(16)) dut (
    .USER_CLK    (clk),
    .USER_RST_N  (rst_n),
    .Result_Valid(result_valid),
    .Result      (result),
    .Result_Error(result_error),
    .Result_Ready(result_ready),
    .TX_Request  (tx_request),
    .TX_Data     (tx_data),
    .Busy        (busy)
  );

  assign busy = busy_tx | busy_force;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: Busy rises the cycle after a request and stays up for frame_len cycles.
  always @(posedge clk) begin
    if (tx_request && !busy_tx) begin
      busy_tx  <= 1'b1;
      busy_cnt <= frame_len;
    end else if (busy_tx) begin
      if (busy_cnt <= 1) busy_tx <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_request) begin
      check("req_while_busy", 32'(busy), 0);
      check("req_one_cycle", 32'(prev_req), 0);
      if (exp_q.size() == 0) check("extra_char", exp_q.size(), 1);
      else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      req_count++;
      last_req_cyc = cyc;
    end
    prev_req = tx_request;
  end

  task automatic push_expected(input int value, input logic err, output int n);
    logic [7:0] s[$];
    int mag, p, d;
    logic started;
    if (err) s = '{8'h45, 8'h52, 8'h52};
    else begin
      mag = (value < 0) ? -value : value;
      if (value < 0) s.push_back(8'h2D);
      p = 10000;
      started = 1'b0;
      for (int k = 0; k < 5; k++) begin
        d = (mag / p) % 10;
        if (d != 0 || started || p == 1) begin
          s.push_back(8'(8'h30 + d));
          started = 1'b1;
        end
        p = p / 10;
      end
    end
    s.push_back(8'h0D);
    s.push_back(8'h0A);
    n = s.size();
    foreach (s[i]) exp_q.push_back(s[i]);
  endtask

  task automatic send(input int value, input logic err, input int lat);
    @(negedge clk);
    check("ready_before_send", 32'(result_ready), 1);
    push_expected(value, err, line_len);
    line_start   = req_count;
    result       = 16'(value);
    result_error = err;
    result_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    result_valid = 1'b0;
    result       = 16'sd0;
    result_error = 1'b0;
    if (lat != 0) begin
      for (int i = 0; i < lat + 10; i++) begin
        @(negedge clk);
        #1;
        if (req_count > line_start) break;
      end
      check("first_req_seen", 32'(req_count - line_start), 1);
      check("first_req_latency", 32'(last_req_cyc - acc_cyc + 1), 32'(lat));
    end
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && result_ready) break;
    end
    check("queue_drained", exp_q.size(), 0);
    check("ready_back", 32'(result_ready), 1);
    check("req_count", 32'(req_count - line_start), 32'(line_len));
  endtask

  initial begin
    rst_n        = 1'b0;
    result_valid = 1'b0;
    result       = 16'sd0;
    result_error = 1'b0;
    busy_force   = 1'b0;
    frame_len    = 11 * 868;
    repeat (3) @(negedge clk);
    check("rst_tx_request", 32'(tx_request), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_ready", 32'(result_ready), 1);
    rst_n = 1'b1;

    send(1234, 1'b0, 19);
    wait_done(70000);

    frame_len = 40;
    send(0, 1'b0, 19);
    wait_done(2000);
    send(-32768, 1'b0, 19);
    wait_done(2000);

    // Valid pulses mid-line must not disturb the line in flight.
    send(32767, 1'b0, 19);
    for (int i = 0; i < 500 && (req_count - line_start) < 2; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      result_valid = 1'b1;
      result       = 16'sd999;
      @(negedge clk);
      result_valid = 1'b0;
      repeat (6) @(negedge clk);
    end
    wait_done(2000);

    send(5, 1'b1, 3);
    wait_done(2000);

    busy_force = 1'b1;
    send(42, 1'b0, 0);
    repeat (500) @(negedge clk);
    check("held_off_by_busy", 32'(req_count - line_start), 0);
    busy_force = 1'b0;
    wait_done(2000);

    // Asynchronous reset during the third character.
    send(32767, 1'b0, 19);
    for (int i = 0; i < 1000 && (req_count - line_start) < 3; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx_request", 32'(tx_request), 0);
    check("async_rst_tx_data", 32'(tx_data), 0);
    check("async_rst_ready", 32'(result_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(-7, 1'b0, 0);
    wait_done(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
